// File: rtl/addsub_arbiter.sv
// Round-robin sequencer that shares one combinational add/sub unit among NREQ requesters.
// Operands are registered toward the unit, and the result and flags are held on a valid/ready response port.
module addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [31:0]          au_a,
  output logic [31:0]          au_b,
  output logic                 au_sub,
  input  logic [31:0]          au_res,
  input  logic                 au_v,
  input  logic                 au_c,
  input  logic                 au_z,
  input  logic                 au_s,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_res,
  output logic [3:0]           rsp_flags,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [31:0]      au_a_q, au_a_d;
  logic [31:0]      au_b_q, au_b_d;
  logic             au_sub_q, au_sub_d;
  logic [31:0]      rsp_res_q;
  logic [3:0]       rsp_flags_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             hi_found, lo_found;
  logic [IDW-1:0]   hi_idx, lo_idx, win_idx;
  logic             can_grant, grant;

  // Lowest valid index above last_q wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = i[IDW-1:0];
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = i[IDW-1:0];
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign can_grant = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign grant     = can_grant && lo_found;

  always_comb begin
    au_a_d   = au_a_q;
    au_b_d   = au_b_q;
    au_sub_d = au_sub_q;
    if (grant) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win_idx == i[IDW-1:0]) begin
          au_a_d   = req_a[32*i +: 32];
          au_b_d   = req_b[32*i +: 32];
          au_sub_d = req_sub[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (win_idx == i[IDW-1:0])) req_ready[i] = 1'b1;
    end
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Operands change only on a grant edge; the result is captured at the end of the single EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      au_a_q      <= '0;
      au_b_q      <= '0;
      au_sub_q    <= 1'b0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      au_a_q   <= au_a_d;
      au_b_q   <= au_b_d;
      au_sub_q <= au_sub_d;
      if (grant) begin
        id_q   <= win_idx;
        last_q <= win_idx;
      end
      if (state_q == EXEC) begin
        rsp_res_q   <= au_res;
        rsp_flags_q <= {au_v, au_c, au_z, au_s};
        rsp_id_q    <= id_q;
      end
    end
  end

  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_sub    = au_sub_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with NREQ=2: a vector table of single operations,
// plus hand-written sequences for round-robin, stall, pulsed requests and reset.
module tb_addsub_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic [31:0]         au_a, au_b, au_res;
  logic                au_sub, au_v, au_c, au_z, au_s;
  logic                rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_res;
  logic [3:0]          rsp_flags;

  int checkCount = 0;
  int failCount  = 0;

  addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .au_a(au_a), .au_b(au_b), .au_sub(au_sub),
    .au_res(au_res), .au_v(au_v), .au_c(au_c), .au_z(au_z), .au_s(au_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural shared unit; subtraction is A + ~B + 1, so carry-out means no borrow.
  logic [32:0] sum;
  always_comb begin
    sum    = au_sub ? ({1'b0, au_a} + {1'b0, ~au_b} + 33'd1) : ({1'b0, au_a} + {1'b0, au_b});
    au_res = sum[31:0];
    au_c   = sum[32];
    au_z   = (sum[31:0] == 32'd0);
    au_s   = sum[31];
    au_v   = au_sub ? ((au_a[31] != au_b[31]) && (sum[31] != au_a[31]))
                    : ((au_a[31] == au_b[31]) && (sum[31] != au_a[31]));
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] expRes;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [NREQ-1:0] oneHot;
    oneHot        = '0;
    oneHot[v.id]  = 1'b1;
    req_a         = '0;
    req_b         = '0;
    req_sub       = '0;
    req_a[32*v.id +: 32] = v.a;
    req_b[32*v.id +: 32] = v.b;
    req_sub[v.id] = v.sub;
    req_valid     = oneHot;
    rsp_ready     = 1'b0;
    #1;
    for (int w = 0; w < 10 && req_ready == '0; w++) begin
      tick();
      #1;
    end
    checkOutput("vec_req_ready", 32'(req_ready), 32'(oneHot));
    tick();
    req_valid = '0;
    #1;
    checkOutput("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("vec_rsp_id", 32'(rsp_id), 32'(v.id));
    checkOutput("vec_rsp_res", rsp_res, v.expRes);
    checkOutput("vec_rsp_flags", 32'(rsp_flags), 32'(v.expFlags));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("vec_after_pop_valid", 32'(rsp_valid), 32'd0);
    checkOutput("vec_after_pop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int id0Count, id1Count;
    logic [NREQ-1:0] expReady;
    logic            expValid;
    int              prevId;

    vecs[0] = '{0, 32'd5,          32'd3,  1'b1, 32'd2,          4'b0100};
    vecs[1] = '{0, 32'd3,          32'd3,  1'b1, 32'd0,          4'b0110};
    vecs[2] = '{0, 32'd0,          32'd1,  1'b1, 32'hFFFFFFFF,   4'b0001};
    vecs[3] = '{1, 32'h7FFFFFFF,   32'd1,  1'b0, 32'h80000000,   4'b1001};
    vecs[4] = '{1, 32'hFFFFFFFF,   32'd1,  1'b0, 32'd0,          4'b0110};
    vecs[5] = '{0, 32'h80000000,   32'd1,  1'b1, 32'h7FFFFFFF,   4'b1100};
    vecs[6] = '{1, 32'h12345678,   32'h11111111, 1'b0, 32'h23456789, 4'b0000};

    req_a = '0; req_b = '0; req_sub = '0; req_valid = '0; rsp_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    doReset();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_au_a", au_a, 32'd0);
    checkOutput("reset_rsp_res", rsp_res, 32'd0);

    for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

    // Round robin with both requesters always valid and the consumer always ready.
    doReset();
    req_a     = {32'd20, 32'd10};
    req_b     = {32'd2,  32'd1};
    req_sub   = 2'b10;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      expReady = (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      expValid = (c >= 2) && (c % 2 == 0);
      checkOutput($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(expReady));
      checkOutput($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'(expValid));
      if (expValid) begin
        prevId = ((c / 2) - 1) % 2;
        checkOutput($sformatf("rr_id_c%0d", c), 32'(rsp_id), 32'(prevId));
        checkOutput($sformatf("rr_res_c%0d", c), rsp_res, (prevId == 0) ? 32'd11 : 32'd18);
      end
      tick();
    end

    // Stalled response holds, with a pulsed req1 that must never be served.
    doReset();
    req_a     = {32'h7FFFFFFF, 32'd9};
    req_b     = {32'd1, 32'd4};
    req_sub   = 2'b01;
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    #1;
    checkOutput("stall_grant1", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b01;
    #1;
    checkOutput("stall_exec_ready", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 2) ? 2'b11 : 2'b01;
      #1;
      checkOutput($sformatf("stall_valid_c%0d", c), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("stall_res_c%0d", c), rsp_res, 32'h80000000);
      checkOutput($sformatf("stall_flags_c%0d", c), 32'(rsp_flags), 32'b1001);
      checkOutput($sformatf("stall_id_c%0d", c), 32'(rsp_id), 32'd1);
      checkOutput($sformatf("stall_ready_c%0d", c), 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checkOutput("stall_release_grant0", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    id0Count  = 0;
    id1Count  = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rsp_valid) begin
        if (rsp_id == 1'b1) id1Count++;
        else begin
          id0Count++;
          checkOutput("stall_req0_res", rsp_res, 32'd5);
          checkOutput("stall_req0_flags", 32'(rsp_flags), 32'b0100);
        end
      end
      tick();
    end
    checkOutput("pulse_id1_responses", 32'(id1Count), 32'd0);
    checkOutput("pulse_id0_responses", 32'(id0Count), 32'd1);

    // Reset during EXEC and during RESP drops the operation and restarts priority at req0.
    doReset();
    req_a     = {32'd40, 32'd1};
    req_b     = {32'd4,  32'd1};
    req_sub   = 2'b00;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b11;
    rst       = 1'b1;
    #1;
    checkOutput("rst_exec_no_accept", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    checkOutput("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_exec_busy", 32'(busy), 32'd0);
    checkOutput("rst_exec_au_a", au_a, 32'd0);
    checkOutput("rst_exec_au_b", au_b, 32'd0);
    checkOutput("rst_exec_au_sub", 32'(au_sub), 32'd0);
    #1;
    checkOutput("rst_exec_next_grant0", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    tick();
    checkOutput("rst_resp_pre_res", rsp_res, 32'd2);
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    rst = 1'b0;
    checkOutput("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_resp_busy", 32'(busy), 32'd0);
    checkOutput("rst_resp_res", rsp_res, 32'd0);
    checkOutput("rst_resp_flags", 32'(rsp_flags), 32'd0);
    checkOutput("rst_resp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_resp_au_a", au_a, 32'd0);
    #1;
    checkOutput("rst_resp_next_grant0", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
